// File: rtl/pakin_asm.sv
// Packet reassembler: rebuilds {src,dst,dat,red} from start-marked packets,
// checks redundancy and hands good messages downstream over four-phase req/ack.
module pakin_asm #(
    parameter int PSZ = 4,
    parameter int ASZ = 6,
    parameter int DSZ = 32,
    parameter int RSZ = 4
) (
    input  logic           src_clk,
    input  logic           reset,
    input  logic [PSZ:0]   i_pakio,
    input  logic           i_req,
    output logic           i_ack,
    output logic [ASZ-1:0] o_src,
    output logic [ASZ-1:0] o_dst,
    output logic [DSZ-1:0] o_dat,
    output logic [RSZ-1:0] o_red,
    output logic           o_req,
    input  logic           o_ack,
    output logic [7:0]     msg_cnt,
    output logic [7:0]     err_red_cnt,
    output logic [7:0]     err_sync_cnt
);

    localparam int MSZ     = 2*ASZ + DSZ + RSZ;
    localparam int TOT_PKS = (MSZ + PSZ - 1) / PSZ;
    localparam int BSZ     = TOT_PKS * PSZ;
    localparam int IW      = $clog2(TOT_PKS + 1);
    localparam int PW      = 2*ASZ + DSZ;
    localparam int NCH     = (PW + RSZ - 1) / RSZ;
    localparam logic [IW-1:0] LAST = IW'(TOT_PKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_EMIT,
        S_RELEASE
    } state_t;

    // Redundancy: XOR fold of {src,dst,dat} into RSZ-bit chunks, zero-padded at the top.
    function automatic logic [RSZ-1:0] calc_redun(input logic [PW-1:0] v);
        logic [NCH*RSZ-1:0] p;
        logic [RSZ-1:0]     r;
        p         = '0;
        p[PW-1:0] = v;
        r         = '0;
        for (int j = 0; j < NCH; j++) begin
            r = r ^ p[j*RSZ +: RSZ];
        end
        return r;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    state_t         state_q, state_d;
    logic           req_s1_q, req_s_q;
    logic           ack_s1_q, ack_s_q;
    logic           iack_q, iack_d;
    logic           oreq_q, oreq_d;
    logic [ASZ-1:0] src_q, src_d;
    logic [ASZ-1:0] dst_q, dst_d;
    logic [DSZ-1:0] dat_q, dat_d;
    logic [RSZ-1:0] red_q, red_d;
    logic [7:0]     msg_cnt_q, msg_cnt_d;
    logic [7:0]     err_red_q, err_red_d;
    logic [7:0]     err_sync_q, err_sync_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [BSZ-1:0] buf_q, buf_d;

    logic           accept;
    logic           start;
    logic [PSZ-1:0] pay;
    logic [MSZ-1:0] msg;
    logic [ASZ-1:0] rx_src;
    logic [ASZ-1:0] rx_dst;
    logic [DSZ-1:0] rx_dat;
    logic [RSZ-1:0] rx_red;

    assign start  = i_pakio[PSZ];
    assign pay    = i_pakio[PSZ-1:0];
    assign msg    = buf_q[BSZ-1 -: MSZ];
    assign rx_src = msg[MSZ-1 -: ASZ];
    assign rx_dst = msg[MSZ-1-ASZ -: ASZ];
    assign rx_dat = msg[RSZ +: DSZ];
    assign rx_red = msg[RSZ-1:0];

    assign accept = req_s_q && !iack_q &&
                    (state_q == S_IDLE || state_q == S_COLLECT);

    always_comb begin
        state_d    = state_q;
        iack_d     = iack_q;
        oreq_d     = oreq_q;
        src_d      = src_q;
        dst_d      = dst_q;
        dat_d      = dat_q;
        red_d      = red_q;
        msg_cnt_d  = msg_cnt_q;
        err_red_d  = err_red_q;
        err_sync_d = err_sync_q;
        idx_d      = idx_q;
        buf_d      = buf_q;

        if (accept) begin
            iack_d = 1'b1;
        end else if (!req_s_q) begin
            iack_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE, S_COLLECT: begin
                if (accept) begin
                    if (start) begin
                        // A start marker mid-message resyncs onto the new message.
                        if (state_q == S_COLLECT) begin
                            err_sync_d = sat_inc(err_sync_q);
                        end
                        buf_d   = {{(BSZ-PSZ){1'b0}}, pay};
                        idx_d   = IW'(1);
                        state_d = S_COLLECT;
                    end else if (state_q == S_IDLE) begin
                        err_sync_d = sat_inc(err_sync_q);
                    end else begin
                        buf_d = {buf_q[BSZ-PSZ-1:0], pay};
                        idx_d = idx_q + IW'(1);
                    end
                    if ((start || state_q == S_COLLECT) && idx_d == LAST) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                idx_d = '0;
                if (rx_red == calc_redun({rx_src, rx_dst, rx_dat})) begin
                    src_d   = rx_src;
                    dst_d   = rx_dst;
                    dat_d   = rx_dat;
                    red_d   = rx_red;
                    oreq_d  = 1'b1;
                    state_d = S_EMIT;
                end else begin
                    err_red_d = sat_inc(err_red_q);
                    state_d   = S_IDLE;
                end
            end
            S_EMIT: begin
                if (ack_s_q) begin
                    oreq_d    = 1'b0;
                    msg_cnt_d = sat_inc(msg_cnt_q);
                    state_d   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!ack_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge src_clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            req_s1_q   <= 1'b0;
            req_s_q    <= 1'b0;
            ack_s1_q   <= 1'b0;
            ack_s_q    <= 1'b0;
            iack_q     <= 1'b0;
            oreq_q     <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            dat_q      <= '0;
            red_q      <= '0;
            msg_cnt_q  <= '0;
            err_red_q  <= '0;
            err_sync_q <= '0;
            idx_q      <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_s1_q   <= i_req;
            req_s_q    <= req_s1_q;
            ack_s1_q   <= o_ack;
            ack_s_q    <= ack_s1_q;
            iack_q     <= iack_d;
            oreq_q     <= oreq_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            dat_q      <= dat_d;
            red_q      <= red_d;
            msg_cnt_q  <= msg_cnt_d;
            err_red_q  <= err_red_d;
            err_sync_q <= err_sync_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
        end
    end

    assign i_ack        = iack_q;
    assign o_req        = oreq_q;
    assign o_src        = src_q;
    assign o_dst        = dst_q;
    assign o_dat        = dat_q;
    assign o_red        = red_q;
    assign msg_cnt      = msg_cnt_q;
    assign err_red_cnt  = err_red_q;
    assign err_sync_cnt = err_sync_q;

endmodule
